// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: owns the x16 baud-tick divisor, takes software writes and optional autobaud.
// Autobaud hardware (rx synchronizer, measurement FSM, T counter) is built only with UART_AUTOBAUD_EN.
module uart_baud_ctrl #(
   parameter logic [10:0] DEFAULT_DVSR = 11'd325
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_wr_valid,
   input  logic [10:0] i_wr_dvsr,
   output logic        o_wr_ready,
   input  logic        i_auto_req,
   input  logic        i_rx,
   output logic [10:0] o_dvsr,
   output logic        o_gen_rst,
   output logic        o_auto_busy,
   output logic        o_auto_done,
   output logic        o_auto_err,
   output logic        o_cfg_err
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IDLE,
      WAIT_FALL,
      MEASURE,
      APPLY
   } state_t;

   state_t state_reg;
   logic   wr_fire;
   logic   wr_zero;

   assign o_wr_ready = (state_reg == IDLE);
   assign wr_fire    = i_wr_valid && o_wr_ready;
   assign wr_zero    = (i_wr_dvsr == 11'd0);

`ifdef UART_AUTOBAUD_EN
   logic        rx_meta_reg;
   logic        rx_sync_reg;
   logic        rx_prev_reg;
   logic        rx_fall;
   logic        rx_rise;
   logic [15:0] t_reg;
   logic [16:0] cand;
   logic        cand_ok;

   // Flops reset to idle-high so leaving reset never looks like a start bit.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= i_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign rx_fall = rx_prev_reg & ~rx_sync_reg;
   assign rx_rise = ~rx_prev_reg & rx_sync_reg;

   // A start bit spans 16 ticks: round T/16 to nearest, minus one for the period+1 counter.
   assign cand    = ((({1'b0, t_reg}) + 17'd8) >> 4) - 17'd1;
   assign cand_ok = (cand >= 17'd1) && (cand <= 17'd2047);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg   <= IDLE;
         o_dvsr      <= DEFAULT_DVSR;
         o_gen_rst   <= 1'b1;
         o_auto_busy <= 1'b0;
         o_auto_done <= 1'b0;
         o_auto_err  <= 1'b0;
         o_cfg_err   <= 1'b0;
         t_reg       <= 16'd0;
      end else begin
         o_gen_rst   <= 1'b0;
         o_auto_done <= 1'b0;
         o_auto_err  <= 1'b0;
         o_cfg_err   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (wr_fire) begin
                  if (wr_zero) begin
                     o_cfg_err <= 1'b1;
                  end else begin
                     o_dvsr    <= i_wr_dvsr;
                     o_gen_rst <= 1'b1;
                  end
               end else if (i_auto_req) begin
                  state_reg   <= WAIT_IDLE;
                  o_auto_busy <= 1'b1;
               end
            end
            WAIT_IDLE: begin
               if (rx_sync_reg) begin
                  state_reg <= WAIT_FALL;
               end
            end
            WAIT_FALL: begin
               if (rx_fall) begin
                  state_reg <= MEASURE;
                  t_reg     <= 16'd1;
               end else begin
                  t_reg <= 16'd0;
               end
            end
            MEASURE: begin
               if (rx_rise) begin
                  state_reg <= APPLY;
               end else if (t_reg == 16'hFFFF) begin
                  state_reg   <= IDLE;
                  o_auto_busy <= 1'b0;
                  o_auto_err  <= 1'b1;
               end else if (!rx_sync_reg) begin
                  t_reg <= t_reg + 16'd1;
               end
            end
            APPLY: begin
               state_reg   <= IDLE;
               o_auto_busy <= 1'b0;
               if (cand_ok) begin
                  o_dvsr      <= cand[10:0];
                  o_gen_rst   <= 1'b1;
                  o_auto_done <= 1'b1;
               end else begin
                  o_auto_err <= 1'b1;
               end
            end
            default: begin
               state_reg   <= IDLE;
               o_auto_busy <= 1'b0;
            end
         endcase
      end
   end
`else
   // Without autobaud the rx line and request are dead inputs.
   wire unused_inputs = &{1'b0, i_auto_req, i_rx};

   assign o_auto_busy = 1'b0;
   assign o_auto_done = 1'b0;
   assign o_auto_err  = 1'b0;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_reg <= IDLE;
         o_dvsr    <= DEFAULT_DVSR;
         o_gen_rst <= 1'b1;
         o_cfg_err <= 1'b0;
      end else begin
         state_reg <= IDLE;
         o_gen_rst <= 1'b0;
         o_cfg_err <= 1'b0;
         if (wr_fire) begin
            if (wr_zero) begin
               o_cfg_err <= 1'b1;
            end else begin
               o_dvsr    <= i_wr_dvsr;
               o_gen_rst <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl: stimulus queues expected pulse events, a monitor pops and compares.
module tb_uart_baud_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic [10:0] wr_dvsr;
   logic        wr_ready;
   logic        auto_req;
   logic        rx;
   logic [10:0] dvsr;
   logic        gen_rst;
   logic        auto_busy;
   logic        auto_done;
   logic        auto_err;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;
   int model_dvsr;
   logic [14:0] exp_q[$];   // {code, dvsr}; code = {gen_rst, cfg_err, auto_done, auto_err}
   logic [3:0]  mon_code;
   logic [14:0] mon_exp;

   localparam logic [3:0] EV_LOAD = 4'b1000;
   localparam logic [3:0] EV_CFG  = 4'b0100;
   localparam logic [3:0] EV_DONE = 4'b1010;
   localparam logic [3:0] EV_AERR = 4'b0001;

   always #5 clk = ~clk;

   uart_baud_ctrl dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_wr_valid  (wr_valid),
      .i_wr_dvsr   (wr_dvsr),
      .o_wr_ready  (wr_ready),
      .i_auto_req  (auto_req),
      .i_rx        (rx),
      .o_dvsr      (dvsr),
      .o_gen_rst   (gen_rst),
      .o_auto_busy (auto_busy),
      .o_auto_done (auto_done),
      .o_auto_err  (auto_err),
      .o_cfg_err   (cfg_err)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] code, input int d);
      logic [10:0] d11;
      d11 = d[10:0];
      exp_q.push_back({code, d11});
   endtask

   // Monitor: every pulse-output event must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && (gen_rst || cfg_err || auto_done || auto_err)) begin
            mon_code = {gen_rst, cfg_err, auto_done, auto_err};
            $display("EVT t=%0t code=%b dvsr=%0d", $time, mon_code, dvsr);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got code %b dvsr %0d expected no event", mon_code, dvsr);
            end else begin
               mon_exp = exp_q.pop_front();
               check("event_code", int'(mon_code), int'(mon_exp[14:11]));
               check("event_dvsr", int'(dvsr), int'(mon_exp[10:0]));
            end
         end
      end
   end

   task automatic do_write(input logic [10:0] v);
      int n = 0;
      wr_valid = 1'b1;
      wr_dvsr  = v;
      while (!wr_ready && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!wr_ready) begin
         checks++;
         errors++;
         $display("FAIL write_timeout: ready %0d expected 1", wr_ready);
         wr_valid = 1'b0;
         return;
      end
      if (v == 11'd0) begin
         push_exp(EV_CFG, model_dvsr);
      end else begin
         model_dvsr = int'(v);
         push_exp(EV_LOAD, model_dvsr);
      end
      $display("WR  t=%0t dvsr=%0d stall=%0d", $time, v, n);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic auto_measure(input int w);
      int cand;
      int n = 0;
      auto_req = 1'b1;
      @(posedge clk); #1;
      auto_req = 1'b0;
      check("auto_busy_set", int'(auto_busy), 1);
      check("wr_ready_busy", int'(wr_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      // T is the low width in cycles, capped at 65535 where the measurement is abandoned.
      cand = (w + 8) / 16 - 1;
      if (w >= 65535 || cand < 1 || cand > 2047) begin
         push_exp(EV_AERR, model_dvsr);
      end else begin
         model_dvsr = cand;
         push_exp(EV_DONE, model_dvsr);
      end
      $display("AB  t=%0t low=%0d expect_dvsr=%0d", $time, w, model_dvsr);
      rx = 1'b0;
      repeat (w) @(posedge clk);
      #1;
      rx = 1'b1;
      while (auto_busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("auto_busy_clear", int'(auto_busy), 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_dvsr  = 11'd0;
      auto_req = 1'b0;
      rx       = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dvsr", int'(dvsr), 325);
      check("rst_gen_rst", int'(gen_rst), 1);
      check("rst_busy", int'(auto_busy), 0);
      check("rst_done", int'(auto_done), 0);
      check("rst_aerr", int'(auto_err), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      @(posedge clk); #1;
      model_dvsr = 325;
      push_exp(EV_LOAD, 325);   // generator reset held through first post-reset cycle
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_wr_ready", int'(wr_ready), 1);
      @(negedge clk);
      check("gen_rst_released", int'(gen_rst), 0);
      @(posedge clk); #1;

      do_write(11'd26);
      do_write(11'd0);
      repeat (3) @(posedge clk);
      #1;
      check("dvsr_after_reject", int'(dvsr), 26);

      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(3) == 0) do_write(11'd0);
         else do_write(11'($urandom_range(2047, 1)));
         repeat ($urandom_range(3)) @(posedge clk);
         #1;
      end
      do_write(dvsr);   // rewriting the same value still pulses the generator reset

      // Write and autobaud request together: write wins, request dropped.
      wr_valid = 1'b1;
      wr_dvsr  = 11'd91;
      auto_req = 1'b1;
      model_dvsr = 91;
      push_exp(EV_LOAD, 91);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      auto_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("simul_busy", int'(auto_busy), 0);
      end
      @(posedge clk); #1;

`ifdef UART_AUTOBAUD_EN
      auto_measure(434);
      auto_measure(5208);
      auto_measure(20);
      auto_measure(23);
      auto_measure(24);
      for (int i = 0; i < 4; i++) begin
         auto_measure(int'($urandom_range(1500, 8)));
         do_write(11'($urandom_range(2047, 1)));
      end
      auto_measure(66000);
      check("sat_wr_ready", int'(wr_ready), 1);

      // Write during MEASURE stalls until the measurement finishes.
      fork
         auto_measure(434);
         begin
            repeat (200) @(posedge clk);
            #1;
            check("stall_wr_ready", int'(wr_ready), 0);
            do_write(11'd100);
         end
      join
      repeat (3) @(posedge clk);
      #1;
      check("stall_dvsr", int'(dvsr), 100);

      // Reset during MEASURE: back to default divisor, no done/err.
      do_write(11'd77);
      auto_req = 1'b1;
      @(posedge clk); #1;
      auto_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("measure_busy", int'(auto_busy), 1);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx = 1'b1;
      model_dvsr = 325;
      push_exp(EV_LOAD, 325);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", int'(auto_busy), 0);
      check("rst_mid_dvsr", int'(dvsr), 325);
      repeat (10) @(posedge clk);
      #1;
`else
      // Autobaud not built: request and rx activity must do nothing.
      auto_req = 1'b1;
      @(posedge clk); #1;
      auto_req = 1'b0;
      rx = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      check("noab_busy", int'(auto_busy), 0);
      check("noab_wr_ready", int'(wr_ready), 1);
      rx = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("noab_dvsr", int'(dvsr), 91);
      do_write(11'd55);
`endif

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Divisor controller for the UART's x16 baud sample-tick generator. Owns the 11-bit divisor register that drives the generator's divisor input, accepts software divisor writes over a valid/ready handshake, and optionally measures an incoming start bit to set the divisor automatically (autobaud). Every divisor change restarts the generator phase through a one-cycle generator-reset pulse.

## Interface
- DEFAULT_DVSR, 11'd325, divisor loaded at reset (x16 tick at 9600 baud from 50 MHz).
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_wr_valid  in  1  software divisor write request.
- i_wr_dvsr  in  11  divisor to load.
- o_wr_ready  out  1  write can be accepted.
- i_auto_req  in  1  single-cycle pulse that starts an autobaud measurement.
- i_rx  in  1  raw UART receive line, asynchronous, idle high.
- o_dvsr  out  11  divisor to the generator; tick period is o_dvsr+1 cycles.
- o_gen_rst  out  1  active-high reset to the generator.
- o_auto_busy  out  1  autobaud measurement in progress.
- o_auto_done  out  1  one-cycle pulse: autobaud divisor applied.
- o_auto_err  out  1  one-cycle pulse: autobaud result rejected.
- o_cfg_err  out  1  one-cycle pulse: software write rejected.

## Operation
- Reset values: o_dvsr=DEFAULT_DVSR, o_gen_rst=1, o_auto_busy=0, o_auto_done=0, o_auto_err=0, o_cfg_err=0. The FSM resets to IDLE. The rx synchronizer flops reset to 1.
- i_rx passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its one-cycle delayed copy.
- FSM states:
  - IDLE: o_wr_ready=1.
  - WAIT_IDLE: wait for synchronized rx=1.
  - WAIT_FALL: wait for a falling edge; clear the 16-bit counter T.
  - MEASURE: T increments once per cycle while rx=0.
  - APPLY: one cycle.
- Transitions:
  - IDLE -> WAIT_IDLE on i_auto_req, unless a write is accepted in the same cycle. The write wins and i_auto_req is dropped.
  - WAIT_IDLE -> WAIT_FALL when rx=1.
  - WAIT_FALL -> MEASURE on a falling edge. T=1 in the first MEASURE cycle.
  - MEASURE -> APPLY on a rising edge.
  - MEASURE -> IDLE with o_auto_err when T reaches 16'hFFFF (saturation).
  - APPLY -> IDLE.
- APPLY arithmetic: candidate = ((T + 8) >> 4) - 1, computed at 17 bits.
  - If 1 <= candidate <= 2047: load o_dvsr and pulse o_auto_done.
  - Otherwise: keep o_dvsr and pulse o_auto_err.
- Software write: accepted when i_wr_valid && o_wr_ready.
  - i_wr_dvsr=0: reject, pulse o_cfg_err, o_dvsr unchanged, no o_gen_rst.
  - Any other value: load o_dvsr.
- o_gen_rst pulses for exactly one cycle on every o_dvsr load, including loads of an unchanged value. It is not pulsed on rejections.
- o_auto_busy=1 in WAIT_IDLE, WAIT_FALL, MEASURE and APPLY. o_wr_ready=0 in those states.
- i_auto_req while busy is ignored.
- Reset asserted mid-measurement: return to IDLE, o_dvsr=DEFAULT_DVSR, no done/err pulse.

## Timing
- Write handshake at edge N: o_dvsr holds the new value and o_gen_rst=1 in cycle N+1; o_gen_rst=0 from N+2.
- Rejected write at edge N: o_cfg_err=1 in cycle N+1 only.
- Autobaud: the synchronizer adds 2 cycles of latency to both edges, so T equals the low-pulse width in cycles.
- From the synchronized rising edge, APPLY completes in 1 cycle. o_dvsr, o_gen_rst and o_auto_done are all asserted together in the cycle after APPLY.
- o_gen_rst stays 1 during reset and for the first cycle after i_rst_n rises, so generator and controller leave reset aligned.
- All outputs are registered. No combinational path from inputs to outputs, except o_wr_ready, which is decoded from state.

## Configuration
- UART_AUTOBAUD_EN defined:
  - Synchronizer, autobaud FSM states and the T counter are built.
- UART_AUTOBAUD_EN undefined:
  - i_auto_req and i_rx are ignored.
  - FSM is IDLE only.
  - o_wr_ready=1 constantly.
  - o_auto_busy, o_auto_done and o_auto_err are tied 0.
  - Software-write behaviour is identical.

## Test plan
- Reset then idle: o_dvsr=325, o_gen_rst=1 through the first post-reset cycle then 0, o_wr_ready=1.
- Write i_wr_dvsr=26 -> o_dvsr=26 and o_gen_rst=1 the next cycle. Then write 0 -> o_cfg_err pulse, o_dvsr stays 26, no o_gen_rst.
- Autobaud (UART_AUTOBAUD_EN), rx low for 434 cycles -> o_dvsr=26, o_auto_done pulse. Low for 5208 cycles -> o_dvsr=325.
- Autobaud with a 20-cycle glitch -> o_auto_err, o_dvsr unchanged. Rx held low 70000 cycles -> o_auto_err at saturation, FSM back in IDLE.
- i_wr_valid and i_auto_req in the same IDLE cycle -> write applied, o_auto_busy stays 0. A write attempted during MEASURE stalls (o_wr_ready=0) until IDLE.
- i_rst_n low mid-MEASURE -> o_dvsr=325, o_auto_busy=0, no done/err. Without the macro: i_auto_req has no effect and o_wr_ready=1 always.
